framebuffer_writer: RTL and testbench

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

---
 rtl/framebuffer_pkg.sv | 24 ++
 rtl/framebuffer_writer_pixel_fifo.sv | 61 ++++++
 rtl/framebuffer_writer.sv | 176 +++++++++++++++++
 tb/tb_framebuffer_writer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_pkg.sv
// framebuffer_pkg
//   Shared definitions for the framebuffer writer and the display driver:
//   FSM state encoding, default timing/size constants and a small helper.
package framebuffer_pkg;

  localparam int FB_FRAME_PIXELS = 153600;  // 320 columns x 480 lines of nibbles
  localparam int FB_HOLD_CYCLES  = 4;
  localparam int FB_RESET_CYCLES = 8;
  localparam int FB_FIFO_DEPTH   = 4;
  localparam int FB_PIXEL_W      = 4;

  typedef enum logic [2:0] {
    PTR_RESET = 3'd0,
    IDLE      = 3'd1,
    STROBE    = 3'd2,
    WAIT_ACK  = 3'd3,
    HOLD      = 3'd4
  } fb_state_e;

  function automatic int fb_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/framebuffer_writer_pixel_fifo.sv
// pixel_fifo
//   Small synchronous FIFO buffering gray nibbles between the Mandelbrot
//   engine and the RAM write handshake. DEPTH must be a power of two (>= 2).
// Ports
//   clk, rst_n        : clock, async active-low reset
//   i_flush           : synchronous clear of all entries (wins over push)
//   i_push / i_data   : write one entry (ignored when full)
//   i_pop             : drop the head entry (ignored when empty)
//   o_data            : head entry, valid when !o_empty
//   o_full / o_empty  : occupancy flags
module pixel_fifo
  import framebuffer_pkg::*;
#(
  parameter int DEPTH = FB_FIFO_DEPTH,
  parameter int WIDTH = FB_PIXEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/framebuffer_writer.sv
// framebuffer_writer
//   Takes gray nibbles from the Mandelbrot engine and writes them one at a
//   time to the QSPI RAM controller with a toggle-strobe / echo handshake,
//   resetting the RAM write pointer at every frame boundary.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   PTR_RESET | hold reset_write_ptr_out for RESET_CYCLES, clear pixel count
//   IDLE      | wait for a buffered nibble, load it onto write_data_out
//   STROBE    | toggle write_strobe_out (one nibble write)
//   WAIT_ACK  | wait for the echoed strobe level to match
//   HOLD      | keep data stable HOLD_CYCLES, then count the pixel
//
// Ports
//   clk, rst_n                 : clock, async active-low reset
//   pixel_in/_valid_in/_ready_out : pixel stream from the engine
//   frame_start_in             : restart at pixel 0
//   write_data_out, write_strobe_out, wrote_data_in : RAM write handshake
//   reset_write_ptr_out        : RAM write pointer reset
//   frame_done_out             : one-cycle pulse after the last nibble
module framebuffer_writer
  import framebuffer_pkg::*;
#(
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
  parameter int HOLD_CYCLES  = FB_HOLD_CYCLES,
  parameter int RESET_CYCLES = FB_RESET_CYCLES,
  parameter int FIFO_DEPTH   = FB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FB_PIXEL_W-1:0] pixel_in,
  input  logic                  pixel_valid_in,
  output logic                  pixel_ready_out,
  input  logic                  frame_start_in,
  output logic [FB_PIXEL_W-1:0] write_data_out,
  output logic                  write_strobe_out,
  output logic                  reset_write_ptr_out,
  input  logic                  wrote_data_in,
  output logic                  frame_done_out
);

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int TMR_W = $clog2(fb_max(RESET_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

  fb_state_e             r_state;
  logic [TMR_W-1:0]      r_tmr;
  logic [CNT_W-1:0]      r_pix_cnt;
  logic                  r_flush_pend;
  logic [FB_PIXEL_W-1:0] r_data;
  logic                  r_strobe;
  logic                  r_rst_ptr;
  logic                  r_done;

  logic [FB_PIXEL_W-1:0] w_fifo_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_hold_done;

  assign pixel_ready_out     = !w_full && !r_flush_pend && (r_state != PTR_RESET);
  assign w_push              = pixel_valid_in && pixel_ready_out;
  assign w_pop               = (r_state == IDLE) && !frame_start_in && !w_empty;
  assign w_hold_done         = (r_state == HOLD) && (r_tmr == HOLD_LAST);
  // A restart requested mid-transfer drops the queue only once the
  // in-flight nibble has finished its hold time.
  assign w_flush             = (frame_start_in && (r_state == IDLE || r_state == PTR_RESET)) ||
                               (w_hold_done && (r_flush_pend || frame_start_in));

  assign write_data_out      = r_data;
  assign write_strobe_out    = r_strobe;
  assign reset_write_ptr_out = r_rst_ptr;
  assign frame_done_out      = r_done;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FB_PIXEL_W)
  ) u_pixel_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (pixel_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PTR_RESET;
      r_tmr        <= '0;
      r_pix_cnt    <= '0;
      r_flush_pend <= 1'b0;
      r_data       <= '0;
      r_strobe     <= 1'b0;
      r_rst_ptr    <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        PTR_RESET: begin
          r_pix_cnt    <= '0;
          r_flush_pend <= 1'b0;
          if (frame_start_in) begin
            r_tmr <= '0;
          end else if (r_tmr == RST_LAST) begin
            r_tmr     <= '0;
            r_rst_ptr <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        IDLE: begin
          if (frame_start_in) begin
            r_tmr     <= '0;
            r_rst_ptr <= 1'b1;
            r_state   <= PTR_RESET;
          end else if (!w_empty) begin
            r_data  <= w_fifo_data;
            r_state <= STROBE;
          end
        end
        STROBE: begin
          if (frame_start_in) r_flush_pend <= 1'b1;
          r_strobe <= ~r_strobe;
          r_state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (frame_start_in) r_flush_pend <= 1'b1;
          if (wrote_data_in == r_strobe) begin
            r_tmr   <= '0;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_hold_done) begin
            r_tmr <= '0;
            if (r_pix_cnt == LAST_PIX) begin
              // Frame end absorbs any pending restart: one pointer reset only.
              r_pix_cnt    <= '0;
              r_done       <= 1'b1;
              r_flush_pend <= 1'b0;
              r_rst_ptr    <= 1'b1;
              r_state      <= PTR_RESET;
            end else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
              if (r_flush_pend || frame_start_in) begin
                r_flush_pend <= 1'b0;
                r_rst_ptr    <= 1'b1;
                r_state      <= PTR_RESET;
              end else begin
                r_state <= IDLE;
              end
            end
          end else begin
            if (frame_start_in) r_flush_pend <= 1'b1;
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: begin
          r_tmr     <= '0;
          r_rst_ptr <= 1'b1;
          r_state   <= PTR_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer
//   Directed bench for framebuffer_writer with FRAME_PIXELS=16 so frame
//   boundaries are reachable. The display echo is modelled as a register
//   that copies write_strobe_out one clock late and can be frozen.
module tb_framebuffer_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pixel_in;
  logic       pixel_valid_in;
  logic       pixel_ready_out;
  logic       frame_start_in;
  logic [3:0] write_data_out;
  logic       write_strobe_out;
  logic       reset_write_ptr_out;
  logic       wrote_data_in;
  logic       frame_done_out;

  logic       echo_en;
  logic       r_echo = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // observation state
  int         cyc = 0;
  int         toggles = 0;
  int         data_changes = 0;
  int         done_cnt = 0;
  int         min_gap = 1000;
  int         last_tog = 0;
  logic [3:0] log_q[$];

  typedef struct {
    logic [3:0] pix;
    logic [3:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  framebuffer_writer #(
    .FRAME_PIXELS (16),
    .HOLD_CYCLES  (4),
    .RESET_CYCLES (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pixel_in            (pixel_in),
    .pixel_valid_in      (pixel_valid_in),
    .pixel_ready_out     (pixel_ready_out),
    .frame_start_in      (frame_start_in),
    .write_data_out      (write_data_out),
    .write_strobe_out    (write_strobe_out),
    .reset_write_ptr_out (reset_write_ptr_out),
    .wrote_data_in       (wrote_data_in),
    .frame_done_out      (frame_done_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (echo_en) r_echo <= write_strobe_out;
  end
  assign wrote_data_in = r_echo;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    logic       prev_strobe;
    logic [3:0] prev_data;
    prev_strobe = 1'b0;
    prev_data   = 4'h0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (write_strobe_out != prev_strobe) begin
          if (toggles > 0 && (cyc - last_tog) < min_gap) min_gap = cyc - last_tog;
          last_tog = cyc;
          toggles++;
          log_q.push_back(write_data_out);
        end
        if (write_data_out != prev_data) data_changes++;
        if (frame_done_out) done_cnt++;
      end
      prev_strobe = write_strobe_out;
      prev_data   = write_data_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Must be called between a rising edge and the following falling edge.
  task automatic push(input logic [3:0] v);
    int k;
    k = 0;
    pixel_in       = v;
    pixel_valid_in = 1'b1;
    @(negedge clk);
    while (!pixel_ready_out && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("push_ready", int'(pixel_ready_out), 1);
    @(posedge clk);
    #1;
    pixel_valid_in = 1'b0;
  endtask

  task automatic wait_toggles(input string name, input int target);
    int k;
    k = 0;
    while (toggles < target && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, toggles, target);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!frame_done_out && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, int'(frame_done_out), 1);
  endtask

  task automatic pulse_frame_start();
    frame_start_in = 1'b1;
    @(posedge clk);
    #1;
    frame_start_in = 1'b0;
  endtask

  // Called just after the edge that raised reset_write_ptr_out (or while it
  // is already high): it must stay high for exactly 8 edges, then stay low.
  task automatic measure_rst_ptr(input string name);
    int n;
    int extra;
    n = 0;
    extra = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (!reset_write_ptr_out) break;
    end
    check({name, "_len"}, n, 8);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (reset_write_ptr_out) extra++;
    end
    check({name, "_single"}, extra, 0);
  endtask

  initial begin
    int base;
    int t0;
    int d0;
    int dn0;
    int k;

    vecs[0] = '{pix: 4'h3, exp_data: 4'h3};
    vecs[1] = '{pix: 4'hA, exp_data: 4'hA};
    vecs[2] = '{pix: 4'hF, exp_data: 4'hF};
    vecs[3] = '{pix: 4'h0, exp_data: 4'h0};
    vecs[4] = '{pix: 4'h5, exp_data: 4'h5};
    vecs[5] = '{pix: 4'hC, exp_data: 4'hC};

    rst_n          = 1'b0;
    pixel_in       = 4'h0;
    pixel_valid_in = 1'b0;
    frame_start_in = 1'b0;
    echo_en        = 1'b1;

    // reset values
    cycles(3);
    check("rst_data",   int'(write_data_out), 0);
    check("rst_strobe", int'(write_strobe_out), 0);
    check("rst_ptr",    int'(reset_write_ptr_out), 1);
    check("rst_ready",  int'(pixel_ready_out), 0);
    check("rst_done",   int'(frame_done_out), 0);

    // release: pointer reset for 8 clocks, then ready
    @(negedge clk);
    rst_n = 1'b1;
    measure_rst_ptr("release_ptr");
    check("release_ready", int'(pixel_ready_out), 1);

    // table of back-to-back pixels
    base = log_q.size();
    for (int i = 0; i < 6; i++) push(vecs[i].pix);
    wait_toggles("vec_toggles", base + 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("vec_data_%0d", i), int'(log_q[base + i]), int'(vecs[i].exp_data));
    check("vec_min_gap_ge4", (min_gap >= 4) ? 1 : 0, 1);
    cycles(10);

    // frozen echo: one nibble stuck in WAIT_ACK, FIFO fills
    echo_en = 1'b0;
    base = log_q.size();
    push(4'h5);
    push(4'h6);
    push(4'h7);
    push(4'h8);
    push(4'h9);
    cycles(2);
    t0 = toggles;
    d0 = data_changes;
    check("stall_inflight_toggle", t0, base + 1);
    cycles(50);
    check("stall_ready",   int'(pixel_ready_out), 0);
    check("stall_toggles", toggles, t0);
    check("stall_data",    data_changes, d0);
    check("stall_strobe_pending", (write_strobe_out != wrote_data_in) ? 1 : 0, 1);
    echo_en = 1'b1;
    wait_toggles("stall_drain", base + 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("stall_data_%0d", i), int'(log_q[base + i]), 5 + i);
    cycles(10);

    // restart from IDLE: count goes back to 0
    pulse_frame_start();
    check("fs_idle_ptr", int'(reset_write_ptr_out), 1);
    check("fs_idle_ready", int'(pixel_ready_out), 0);
    measure_rst_ptr("fs_idle_ptr");

    // a full 16-pixel frame
    base = toggles;
    dn0 = done_cnt;
    for (int i = 0; i < 16; i++) push(4'(i));
    wait_done("frame1_done");
    check("frame1_toggles", toggles - base, 16);
    check("frame1_ready_low", int'(pixel_ready_out), 0);
    check("frame1_ptr_high", int'(reset_write_ptr_out), 1);
    measure_rst_ptr("frame1_ptr");
    check("frame1_done_once", done_cnt - dn0, 1);

    // counter was wrapped to 0: 15 pixels give no frame_done
    base = toggles;
    dn0 = done_cnt;
    for (int i = 0; i < 15; i++) push(4'(15 - i));
    wait_toggles("frame2_15", base + 15);
    cycles(20);
    check("frame2_no_early_done", done_cnt - dn0, 0);

    // restart requested while the last nibble of the frame is in flight
    echo_en = 1'b0;
    push(4'hE);
    wait_toggles("frame2_last", base + 16);
    pulse_frame_start();
    check("frame2_pend_ready", int'(pixel_ready_out), 0);
    echo_en = 1'b1;
    wait_done("frame2_done");
    measure_rst_ptr("frame2_ptr");
    check("frame2_done_once", done_cnt - dn0, 1);

    // restart during WAIT_ACK with two pixels queued
    echo_en = 1'b0;
    base = log_q.size();
    dn0 = done_cnt;
    push(4'hA);
    push(4'hB);
    push(4'hC);
    cycles(3);
    pulse_frame_start();
    check("mid_fs_ready", int'(pixel_ready_out), 0);
    echo_en = 1'b1;
    k = 0;
    while (!reset_write_ptr_out && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_fs_ptr_rise", int'(reset_write_ptr_out), 1);
    measure_rst_ptr("mid_fs_ptr");
    cycles(30);
    check("mid_fs_toggles", log_q.size() - base, 1);
    check("mid_fs_data", int'(log_q[base]), 10);
    check("mid_fs_no_done", done_cnt - dn0, 0);

    // async reset during HOLD
    base = toggles;
    push(4'h9);
    wait_toggles("hold_toggle", base + 1);
    cycles(2);
    check("hold_pre_data", int'(write_data_out), 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_data",   int'(write_data_out), 0);
    check("async_strobe", int'(write_strobe_out), 0);
    check("async_ptr",    int'(reset_write_ptr_out), 1);
    check("async_ready",  int'(pixel_ready_out), 0);
    check("async_done",   int'(frame_done_out), 0);
    cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    measure_rst_ptr("rerelease_ptr");
    check("rerelease_ready", int'(pixel_ready_out), 1);
    base = log_q.size();
    push(4'h2);
    wait_toggles("after_rst_toggle", toggles + 1);
    check("after_rst_data", int'(log_q[base]), 2);
    check("overall_min_gap_ge4", (min_gap >= 4) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
